// File: rtl/qspim_wb_arb.sv
// Round-robin arbiter sharing the QSPI master's Wishbone slave port between NUM_M masters.
// Grants are held until ack/err, followed by a one-cycle gap; a watchdog aborts stalled transfers.
module qspim_wb_arb #(
    parameter int NUM_M    = 3,
    parameter int WB_WIDTH = 32
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_stb_i,
    input  logic [NUM_M*WB_WIDTH-1:0] m_adr_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*WB_WIDTH-1:0] m_dat_i,
    input  logic [NUM_M*4-1:0]        m_sel_i,
    output logic [WB_WIDTH-1:0]       m_dat_o,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [NUM_M-1:0]          m_err_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [WB_WIDTH-1:0]       s_adr_o,
    output logic [WB_WIDTH-1:0]       s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic [WB_WIDTH-1:0]       s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic [15:0]               cfg_tmo_cnt,
    output logic                      tmo_fsm_reset,
    output logic [1:0]                grant_id,
    output logic [7:0]                tmo_err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  grant_r, grant_s;
    logic [1:0]  last_grant_r, last_grant_s;
    logic [15:0] wdog_r;
    logic [7:0]  tmo_cnt_r;
    logic [1:0]  pick_s;
    logic        pick_found_s;
    logic        gstb_s;
    logic        expire_s;

    assign m_dat_o     = s_dat_i;
    assign grant_id    = grant_r;
    assign tmo_err_cnt = tmo_cnt_r;

    // Circular search for the first requester after the last completed grant.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = 2'd0;
        for (int k = 1; k <= NUM_M; k++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!pick_found_s && m_stb_i[i] && (i == (int'(last_grant_r) + k) % NUM_M)) begin
                    pick_found_s = 1'b1;
                    pick_s       = 2'(i);
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Request path mux: follows grant_r, so it holds the last owner's signals outside BUSY.
    always_comb begin
        gstb_s  = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = {WB_WIDTH{1'b0}};
        s_dat_o = {WB_WIDTH{1'b0}};
        s_sel_o = 4'd0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_r == 2'(i)) begin
                gstb_s  = m_stb_i[i];
                s_we_o  = m_we_i[i];
                s_adr_o = m_adr_i[i*WB_WIDTH +: WB_WIDTH];
                s_dat_o = m_dat_i[i*WB_WIDTH +: WB_WIDTH];
                s_sel_o = m_sel_i[i*4 +: 4];
            end else begin
                gstb_s = gstb_s;
            end
        end
    end

    // Arbitration FSM next state plus the combinational strobe/ack/err/timeout outputs.
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        last_grant_s  = last_grant_r;
        s_stb_o       = 1'b0;
        m_ack_o       = {NUM_M{1'b0}};
        m_err_o       = {NUM_M{1'b0}};
        tmo_fsm_reset = 1'b0;
        expire_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    grant_s = pick_s;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                s_stb_o = gstb_s;
                // A completing ack/err beats expiry; >= covers a limit lowered below wdog mid-transfer.
                expire_s = gstb_s && !s_ack_i && !s_err_i && (cfg_tmo_cnt != 16'd0) &&
                           (wdog_r >= cfg_tmo_cnt - 16'd1);
                tmo_fsm_reset = expire_s;
                for (int i = 0; i < NUM_M; i++) begin
                    if (grant_r == 2'(i)) begin
                        m_ack_o[i] = s_ack_i;
                        m_err_o[i] = s_err_i | expire_s;
                    end else begin
                        m_ack_o[i] = 1'b0;
                    end
                end
                if (s_ack_i || s_err_i || !gstb_s || expire_s) begin
                    last_grant_s = grant_r;
                    state_s      = GAP;
                end else begin
                    state_s = BUSY;
                end
            end
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, grant history, watchdog and expiry counter registers.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= 2'd0;
            last_grant_r <= 2'(NUM_M - 1);
            wdog_r       <= 16'd0;
            tmo_cnt_r    <= 8'd0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            if (state_r == BUSY) begin
                wdog_r <= (wdog_r == 16'hFFFF) ? wdog_r : wdog_r + 16'd1;
            end else begin
                wdog_r <= 16'd0;
            end
            if (expire_s && (tmo_cnt_r != 8'hFF)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

endmodule
